spi_master_phase_ctrl: RTL and testbench
========================================

# spi_master_phase_ctrl

Transaction sequencer for the PULPino SPI master subsystem. Takes one SPI transaction descriptor (command, address and MOSI data words, each with its own bit length) and drives the SPI pins through CMD, ADDR and DATA phases in SPI mode 0. During the DATA phase it captures MISO into a right-aligned receive word. It sits between the register front-end (SPILEN/SPICMD/SPIADR/TXFIFO) and the pads. Its field split matches the collector packet used by the verification environment: cmd_len, addr_len and data_len with separate 32-bit fields.

## Interface
- CLKDIV_W, 8, width of the clock-divider input

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a transaction; accepted only when busy=0
- cmd  in  32  command word; low cmd_len bits sent MSB-first
- addr  in  32  address word; low addr_len bits sent MSB-first
- mosi_data  in  32  data word; low data_len bits sent MSB-first
- cmd_len  in  6  command bits, 0..32; values >32 clamp to 32
- addr_len  in  6  address bits, 0..32; values >32 clamp to 32
- data_len  in  6  data bits, 0..32; values >32 clamp to 32
- clk_div  in  CLKDIV_W  SCLK half-period = clk_div+1 clk cycles
- miso  in  1  serial input, sampled on SCLK rise in DATA phase only
- spi_clk  out  1  SCLK, idle low (CPOL=0)
- spi_csn  out  1  chip select, active low
- spi_mosi  out  1  serial output
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at transaction end
- rx_data  out  32  captured MISO bits, right-aligned, upper bits zero

## Operation
- States: IDLE, CMD, ADDR, DATA, FINISH.
- IDLE: when start=1, latch all inputs: words, clamped lengths and clk_div. Later input changes have no effect.
- After IDLE, go to the first phase with nonzero length, in order CMD, ADDR, DATA. If every length is 0, go to FINISH.
- In each phase a bit counter runs from len-1 down to 0. spi_mosi = field[counter].
- After the falling SCLK edge of bit 0, go to the next nonzero phase, or to FINISH if none remains.
- FINISH lasts one cycle: spi_csn=1, spi_clk=0, done=1, busy=0. Then return to IDLE.
- A start in the FINISH cycle is accepted (back-to-back). spi_csn stays high for exactly that one cycle.
- DATA phase is full-duplex: on each SCLK rise, rx_shift = {rx_shift[30:0], miso}.
- The receive shift register is cleared at start acceptance. rx_data updates from it in the FINISH cycle and holds until the next FINISH.
- start while busy=1 is ignored and not queued.

## Timing
- Let D = clk_div+1 and N = total clamped bits. Cycle t0 is the cycle in which start is sampled in IDLE.
- At t0+1: spi_csn=0, busy=1, spi_clk=0, spi_mosi = first bit.
- Each bit occupies 2D cycles. SCLK rises D cycles after the bit starts and falls 2D cycles after it.
- spi_mosi changes only together with a falling SCLK edge, or at phase entry.
- Phase transitions add no gap: the next phase's first bit is driven in the same cycle as the prior phase's last falling edge.
- The FINISH/done cycle is t0+1+2·D·N. If N=0, done is at t0+1 and spi_csn never goes low.
- Reset values (all outputs): spi_clk=0, spi_csn=1, spi_mosi=0, busy=0, done=0, rx_data=0.
- rst mid-transaction aborts on the next edge: all outputs take reset values, the FSM returns to IDLE, and no done pulse is issued.
- The divider counter resets at every start acceptance. There is no partial first half-period.

## Test plan
- Command only: cmd=0x9F, cmd_len=8, other lengths 0, clk_div=0 -> 8 SCLK pulses, MOSI 1,0,0,1,1,1,1,1; spi_csn low 16 cycles; done at t0+17.
- Full transaction: cmd=0x0B, cmd_len=8; addr=0x123456, addr_len=24; data_len=32; MISO drives 0xA5C3_0F81; clk_div=3 -> 64 SCLK pulses; no gaps at phase boundaries; done at t0+1+512; rx_data=0xA5C30F81.
- Short read: data_len=5, MISO bits 1,0,1,1,0 -> rx_data=0x00000016. MISO toggled during CMD/ADDR does not affect rx_data.
- Zero/clamp lengths: all lengths 0 -> done at t0+1, spi_csn stays 1. cmd_len=40 -> exactly 32 bits sent.
- Protocol abuse: start pulsed mid-transfer -> ignored. start in the FINISH cycle -> spi_csn high one cycle, second transfer begins at FINISH+1.
- Reset mid-ADDR phase: rst=1 for one cycle -> next cycle spi_csn=1, spi_clk=0, busy=0, rx_data=0, no done pulse; a following start works normally.

Source files
------------

// File: rtl/spi_master_phase_ctrl.sv
// spi_master_phase_ctrl
// ---------------------
// Sequences one SPI transaction in mode 0 (CPOL=0, CPHA=0): an optional
// command phase, an optional address phase and an optional full-duplex data
// phase. Each field is sent MSB-first from its low <len> bits. MISO is
// captured only during the data phase into a right-aligned receive word.
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   start            transaction request, honoured only when not busy
//   cmd/addr/mosi_data, cmd_len/addr_len/data_len
//                    transaction descriptor (lengths above 32 clamp to 32)
//   clk_div          SCLK half-period is clk_div+1 clk cycles
//   miso             serial input
//   spi_clk, spi_csn, spi_mosi
//                    SPI pins (SCLK idles low, CSn active low)
//   busy             a transaction is on the wire
//   done             one-cycle pulse in the FINISH cycle
//   rx_data          received bits of the last completed transaction

module spi_master_phase_ctrl #(
  parameter int CLKDIV_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [31:0]         cmd,
  input  logic [31:0]         addr,
  input  logic [31:0]         mosi_data,
  input  logic [5:0]          cmd_len,
  input  logic [5:0]          addr_len,
  input  logic [5:0]          data_len,
  input  logic [CLKDIV_W-1:0] clk_div,
  input  logic                miso,
  output logic                spi_clk,
  output logic                spi_csn,
  output logic                spi_mosi,
  output logic                busy,
  output logic                done,
  output logic [31:0]         rx_data
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DATA   = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  // Latched transaction descriptor
  logic [31:0]         cmd_q;
  logic [31:0]         addr_q;
  logic [31:0]         data_q;
  logic [5:0]          cmd_len_q;
  logic [5:0]          addr_len_q;
  logic [5:0]          data_len_q;
  logic [CLKDIV_W-1:0] div_q;

  // Bit timing
  logic [CLKDIV_W-1:0] div_cnt;
  logic                sclk_q;
  logic [4:0]          bit_cnt;
  logic [31:0]         rx_shift;

  // Decoded control
  logic       accept;
  logic       in_phase;
  logic       half_tick;
  logic       rise;
  logic       fall;
  logic       phase_entry;
  logic [5:0] cl_sel;
  logic [5:0] al_sel;
  logic [5:0] dl_sel;
  logic [5:0] entry_len;

  function automatic logic [5:0] clamp_len(input logic [5:0] len);
    return (len > 6'd32) ? 6'd32 : len;
  endfunction

  // Next phase with a nonzero length after 'cur'; IDLE/FINISH mean "from the
  // beginning". Falls through to FINISH when nothing is left to send.
  function automatic state_t phase_after(input state_t cur,
                                         input logic [5:0] cl,
                                         input logic [5:0] al,
                                         input logic [5:0] dl);
    state_t nxt;
    nxt = FINISH;
    case (cur)
      CMD: begin
        if (al != 6'd0)      nxt = ADDR;
        else if (dl != 6'd0) nxt = DATA;
      end
      ADDR: begin
        if (dl != 6'd0) nxt = DATA;
      end
      DATA: nxt = FINISH;
      default: begin
        if (cl != 6'd0)      nxt = CMD;
        else if (al != 6'd0) nxt = ADDR;
        else if (dl != 6'd0) nxt = DATA;
      end
    endcase
    return nxt;
  endfunction

  function automatic logic [5:0] phase_len(input state_t s,
                                           input logic [5:0] cl,
                                           input logic [5:0] al,
                                           input logic [5:0] dl);
    logic [5:0] len;
    case (s)
      CMD:     len = cl;
      ADDR:    len = al;
      DATA:    len = dl;
      default: len = 6'd0;
    endcase
    return len;
  endfunction

  // Next-state and output decode. A start is honoured in IDLE and also in
  // the FINISH cycle, which gives back-to-back transfers with CSn high for
  // exactly one cycle. On acceptance the lengths come straight from the
  // (clamped) inputs because the latched copies are not loaded yet.
  always_comb begin
    state_next  = state;
    in_phase    = (state == CMD) || (state == ADDR) || (state == DATA);
    half_tick   = (div_cnt == div_q);
    rise        = in_phase && half_tick && !sclk_q;
    fall        = in_phase && half_tick && sclk_q;
    accept      = start && ((state == IDLE) || (state == FINISH));
    cl_sel      = accept ? clamp_len(cmd_len)  : cmd_len_q;
    al_sel      = accept ? clamp_len(addr_len) : addr_len_q;
    dl_sel      = accept ? clamp_len(data_len) : data_len_q;

    case (state)
      IDLE: begin
        if (accept) state_next = phase_after(IDLE, cl_sel, al_sel, dl_sel);
      end
      FINISH: begin
        state_next = accept ? phase_after(IDLE, cl_sel, al_sel, dl_sel) : IDLE;
      end
      CMD, ADDR, DATA: begin
        if (fall && (bit_cnt == 5'd0))
          state_next = phase_after(state, cl_sel, al_sel, dl_sel);
      end
      default: state_next = IDLE;
    endcase

    phase_entry = (state_next != state) &&
                  ((state_next == CMD) || (state_next == ADDR) ||
                   (state_next == DATA));
    entry_len   = phase_len(state_next, cl_sel, al_sel, dl_sel);

    spi_clk  = sclk_q;
    spi_csn  = !in_phase;
    busy     = in_phase;
    done     = (state == FINISH);
    case (state)
      CMD:     spi_mosi = cmd_q[bit_cnt];
      ADDR:    spi_mosi = addr_q[bit_cnt];
      DATA:    spi_mosi = data_q[bit_cnt];
      default: spi_mosi = 1'b0;
    endcase
  end

  // State register and datapath. The divider restarts on every phase entry
  // so each phase begins with a full low half-period; bit_cnt only moves on
  // a falling SCLK edge, which is also the only time MOSI may change.
  // rx_data is loaded on the edge into FINISH so it is already valid while
  // done is high; a zero-length transaction reports an empty receive word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      cmd_len_q  <= '0;
      addr_len_q <= '0;
      data_len_q <= '0;
      div_q      <= '0;
      div_cnt    <= '0;
      sclk_q     <= 1'b0;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      rx_data    <= '0;
    end else begin
      state <= state_next;

      if (accept) begin
        cmd_q      <= cmd;
        addr_q     <= addr;
        data_q     <= mosi_data;
        cmd_len_q  <= cl_sel;
        addr_len_q <= al_sel;
        data_len_q <= dl_sel;
        div_q      <= clk_div;
      end

      if (phase_entry) begin
        div_cnt <= '0;
        sclk_q  <= 1'b0;
        bit_cnt <= 5'(entry_len - 6'd1);
      end else if (in_phase) begin
        if (half_tick) begin
          div_cnt <= '0;
          sclk_q  <= !sclk_q;
          if (fall && (bit_cnt != 5'd0)) bit_cnt <= bit_cnt - 5'd1;
        end else begin
          div_cnt <= div_cnt + CLKDIV_W'(1);
        end
      end

      if (accept)
        rx_shift <= '0;
      else if (rise && (state == DATA))
        rx_shift <= {rx_shift[30:0], miso};

      if (state_next == FINISH)
        rx_data <= accept ? 32'd0 : rx_shift;
    end
  end

endmodule

// File: tb/tb_spi_master_phase_ctrl.sv
// tb_spi_master_phase_ctrl
// ------------------------
// Scoreboarded bench for spi_master_phase_ctrl. Each transaction pushes its
// expected done cycle, MOSI bit stream, SCLK/CSn counts and receive word;
// a pin monitor records what the DUT does and the expectation is popped
// when done pulses. A small SPI slave model returns MISO bits per SCLK rise.

module tb_spi_master_phase_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] cmd = '0;
  logic [31:0] addr = '0;
  logic [31:0] mosi_data = '0;
  logic [5:0]  cmd_len = '0;
  logic [5:0]  addr_len = '0;
  logic [5:0]  data_len = '0;
  logic [7:0]  clk_div = '0;
  logic        miso;
  logic        spi_clk;
  logic        spi_csn;
  logic        spi_mosi;
  logic        busy;
  logic        done;
  logic [31:0] rx_data;

  spi_master_phase_ctrl #(.CLKDIV_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cmd       (cmd),
    .addr      (addr),
    .mosi_data (mosi_data),
    .cmd_len   (cmd_len),
    .addr_len  (addr_len),
    .data_len  (data_len),
    .clk_div   (clk_div),
    .miso      (miso),
    .spi_clk   (spi_clk),
    .spi_csn   (spi_csn),
    .spi_mosi  (spi_mosi),
    .busy      (busy),
    .done      (done),
    .rx_data   (rx_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          done_cyc;
    logic [31:0] rx;
    int          nbits;
    logic [127:0] bits;
    int          csn_low;
  } exp_t;

  exp_t sb[$];

  // Pin monitor: accumulate per-transaction observations, snapshot on done
  int           acc_rises = 0;
  int           acc_csn_low = 0;
  logic [127:0] acc_bits = '0;
  int           obs_rises = 0;
  int           obs_csn_low = 0;
  logic [127:0] obs_bits = '0;
  int           done_cnt = 0;
  int           done_base = 0;
  logic         prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      obs_rises   = acc_rises;
      obs_bits    = acc_bits;
      obs_csn_low = acc_csn_low;
      done_cnt    = done_cnt + 1;
      acc_rises   = 0;
      acc_csn_low = 0;
      acc_bits    = '0;
    end else if (spi_csn !== 1'b0) begin
      acc_rises   = 0;
      acc_csn_low = 0;
      acc_bits    = '0;
    end else begin
      acc_csn_low = acc_csn_low + 1;
      if (spi_clk === 1'b1 && prev_sclk === 1'b0) begin
        if (acc_rises < 128) acc_bits[acc_rises] = spi_mosi;
        acc_rises = acc_rises + 1;
      end
    end
    prev_sclk = spi_clk;
  end

  // Slave model: toggles MISO before the data phase, then returns
  // miso_word MSB-first, one bit per SCLK rise
  int          rise_cnt = 0;
  int          pre_bits = 0;
  int          data_bits = 0;
  logic [31:0] miso_word = '0;

  always @(posedge spi_clk or posedge spi_csn) begin
    if (spi_csn === 1'b1) rise_cnt = 0;
    else                  rise_cnt = rise_cnt + 1;
  end

  always @* begin
    if (rise_cnt < pre_bits)
      miso = ~rise_cnt[0];
    else if (rise_cnt < pre_bits + data_bits)
      miso = miso_word[5'(data_bits - 1 - (rise_cnt - pre_bits))];
    else
      miso = 1'b0;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Drive one start pulse, push the expected outcome, then scramble the
  // inputs so that only latched values can produce the right result
  task automatic start_txn(input logic [31:0] c, input logic [31:0] a,
                           input logic [31:0] d, input int cl, input int al,
                           input int dl, input int div, input logic [31:0] mw);
    exp_t        e;
    int          ecl, eal, edl, n, dd, k;
    logic [31:0] mask;
    ecl = (cl > 32) ? 32 : cl;
    eal = (al > 32) ? 32 : al;
    edl = (dl > 32) ? 32 : dl;
    n   = ecl + eal + edl;
    dd  = div + 1;
    pre_bits  = ecl + eal;
    data_bits = edl;
    miso_word = mw;
    cmd       = c;
    addr      = a;
    mosi_data = d;
    cmd_len   = 6'(cl);
    addr_len  = 6'(al);
    data_len  = 6'(dl);
    clk_div   = 8'(div);
    start     = 1'b1;
    done_base = done_cnt;
    mask      = (edl >= 32) ? 32'hFFFF_FFFF : ((32'd1 << edl) - 32'd1);
    e.done_cyc = cyc + 1 + 2 * dd * n;
    e.rx       = mw & mask;
    e.nbits    = n;
    e.csn_low  = 2 * dd * n;
    e.bits     = '0;
    k = 0;
    for (int b = ecl - 1; b >= 0; b--) begin e.bits[k] = c[b]; k++; end
    for (int b = eal - 1; b >= 0; b--) begin e.bits[k] = a[b]; k++; end
    for (int b = edl - 1; b >= 0; b--) begin e.bits[k] = d[b]; k++; end
    sb.push_back(e);
    tick();
    start     = 1'b0;
    cmd       = $urandom;
    addr      = $urandom;
    mosi_data = $urandom;
    cmd_len   = 6'($urandom_range(0, 63));
    addr_len  = 6'($urandom_range(0, 63));
    data_len  = 6'($urandom_range(0, 63));
    clk_div   = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_done(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i <= budget; i++) begin
      if (done_cnt != done_base) begin ok = 1'b1; break; end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s_done_timeout: no done within %0d cycles", name, budget);
    end
  endtask

  // Scoreboard consumer: pop the oldest expectation and compare it with
  // what the monitor saw for the transaction that just finished
  task automatic score_txn(input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s_scoreboard: got done, expected queue empty", name);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (cyc != e.done_cyc) begin
      errors++;
      $display("[TB] FAIL %s_done_cycle: got %0d expected %0d", name, cyc, e.done_cyc);
    end
    checks++;
    if (obs_rises != e.nbits) begin
      errors++;
      $display("[TB] FAIL %s_sclk_pulses: got %0d expected %0d", name, obs_rises, e.nbits);
    end
    checks++;
    if (obs_bits !== e.bits) begin
      errors++;
      $display("[TB] FAIL %s_mosi_bits: got %h expected %h", name, obs_bits, e.bits);
    end
    checks++;
    if (obs_csn_low != e.csn_low) begin
      errors++;
      $display("[TB] FAIL %s_csn_low: got %0d expected %0d", name, obs_csn_low, e.csn_low);
    end
    checks++;
    if (rx_data !== e.rx) begin
      errors++;
      $display("[TB] FAIL %s_rx_data: got %h expected %h", name, rx_data, e.rx);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++; if (spi_clk !== 1'b0) begin errors++; $display("[TB] FAIL reset_spi_clk: got %b expected 0", spi_clk); end
    checks++; if (spi_csn !== 1'b1) begin errors++; $display("[TB] FAIL reset_spi_csn: got %b expected 1", spi_csn); end
    checks++; if (spi_mosi !== 1'b0) begin errors++; $display("[TB] FAIL reset_spi_mosi: got %b expected 0", spi_mosi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (rx_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_rx_data: got %h expected 0", rx_data); end
  endtask

  task automatic test_cmd_only();
    start_txn(32'h9F, 32'h0, 32'h0, 8, 0, 0, 0, 32'h0);
    checks++; if (spi_csn !== 1'b0) begin errors++; $display("[TB] FAIL cmd_first_csn: got %b expected 0", spi_csn); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL cmd_first_busy: got %b expected 1", busy); end
    checks++; if (spi_clk !== 1'b0) begin errors++; $display("[TB] FAIL cmd_first_sclk: got %b expected 0", spi_clk); end
    checks++; if (spi_mosi !== 1'b1) begin errors++; $display("[TB] FAIL cmd_first_mosi: got %b expected 1", spi_mosi); end
    wait_done(100, "cmd_only");
    score_txn("cmd_only");
  endtask

  task automatic test_full();
    start_txn(32'h0B, 32'h0012_3456, 32'h3C5A_9617, 8, 24, 32, 3, 32'hA5C3_0F81);
    wait_done(600, "full");
    score_txn("full");
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL full_busy_at_done: got %b expected 0", busy); end
  endtask

  task automatic test_zero_clamp();
    start_txn(32'h0, 32'h0, 32'h0, 0, 0, 0, 2, 32'h0);
    checks++; if (spi_csn !== 1'b1) begin errors++; $display("[TB] FAIL zero_csn: got %b expected 1", spi_csn); end
    wait_done(10, "zero_len");
    score_txn("zero_len");
    tick();
    start_txn(32'hC000_0003, 32'h0, 32'h0, 40, 0, 0, 0, 32'h0);
    wait_done(100, "clamp");
    score_txn("clamp");
  endtask

  task automatic test_abuse();
    start_txn(32'hA5, 32'h3C, 32'h0, 8, 8, 0, 1, 32'h0);
    repeat (10) tick();
    start    = 1'b1;
    cmd      = 32'hFFFF_FFFF;
    cmd_len  = 6'd3;
    data_len = 6'd7;
    clk_div  = 8'd0;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL abuse_busy: got %b expected 1", busy); end
    wait_done(200, "abuse");
    score_txn("abuse");
    repeat (5) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abuse_idle_busy: got %b expected 0", busy); end
    checks++; if (done_cnt != done_base + 1) begin errors++; $display("[TB] FAIL abuse_done_count: got %0d expected %0d", done_cnt - done_base, 1); end
  endtask

  task automatic test_back_to_back();
    start_txn(32'h3C, 32'h0, 32'h0, 8, 0, 0, 0, 32'h0);
    wait_done(100, "b2b_first");
    score_txn("b2b_first");
    checks++; if (spi_csn !== 1'b1) begin errors++; $display("[TB] FAIL b2b_finish_csn: got %b expected 1", spi_csn); end
    start_txn(32'hC3, 32'h9, 32'h0, 8, 4, 0, 1, 32'h0);
    checks++; if (spi_csn !== 1'b0) begin errors++; $display("[TB] FAIL b2b_second_csn: got %b expected 0", spi_csn); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_busy: got %b expected 1", busy); end
    wait_done(200, "b2b_second");
    score_txn("b2b_second");
  endtask

  task automatic test_short_read();
    start_txn(32'h03, 32'h5A, 32'h1F, 8, 8, 5, 1, 32'h16);
    wait_done(200, "short_read");
    score_txn("short_read");
    repeat (5) tick();
    checks++; if (rx_data !== 32'h16) begin errors++; $display("[TB] FAIL short_read_hold: got %h expected 00000016", rx_data); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL short_read_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_reset_mid_addr();
    exp_t dropped;
    start_txn(32'h0B, 32'h0012_3456, 32'h0, 8, 24, 0, 1, 32'h0);
    repeat (39) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_busy_before: got %b expected 1", busy); end
    rst = 1'b1;
    tick();
    checks++; if (spi_csn !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_csn: got %b expected 1", spi_csn); end
    checks++; if (spi_clk !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_sclk: got %b expected 0", spi_clk); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy); end
    checks++; if (rx_data !== 32'd0) begin errors++; $display("[TB] FAIL rst_mid_rx_data: got %h expected 0", rx_data); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_done: got %b expected 0", done); end
    rst = 1'b0;
    dropped = sb.pop_back();
    done_base = done_cnt;
    repeat (80) tick();
    checks++; if (done_cnt != done_base) begin errors++; $display("[TB] FAIL rst_mid_no_done: got %0d pulses expected 0", done_cnt - done_base); end
    start_txn(32'h9F, 32'h0, 32'h0, 8, 0, 4, 0, 32'hA);
    wait_done(100, "after_reset");
    score_txn("after_reset");
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_cmd_only();
    test_full();
    test_zero_clamp();
    test_abuse();
    test_back_to_back();
    test_short_read();
    test_reset_mid_addr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
